// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program image as a byte stream and writes it
// into instruction memory as little-endian 32-bit words. It checks an XOR
// checksum and then releases the core's reset. All outputs are registered.
module imem_boot_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEN_LO  = 3'd1;
  localparam logic [2:0] LEN_HI  = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] RUN     = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  // Capacity in words; a length above this is rejected before any write.
  localparam logic [31:0] CAP = 32'(64'd1 << ADDR_W);

  logic [2:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  // One bit wider than the address so a full-capacity image never wraps.
  logic [ADDR_W:0]   word_q, word_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rx_ready_q, cpu_reset_q, busy_q, done_q;
  logic              accept;
  logic [15:0]       len_new;

  // rx_ready_q already encodes "not in RUN", so bytes offered in RUN are never taken.
  assign accept  = rx_valid & rx_ready_q;
  assign len_new = {rx_data, len_q[7:0]};

  // Next-state and datapath decode for one accepted byte.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    len_d   = len_q;
    csum_d  = csum_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE, ERROR: begin
        // Non-sync bytes are consumed and discarded.
        if (accept && rx_data == SYNC) begin
          state_d = LEN_LO;
          err_d   = 1'b0;
          word_d  = '0;
          csum_d  = '0;
          lane_d  = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if (32'(len_new) > CAP) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (len_new == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = word_q[ADDR_W-1:0];
            wdata_d = {rx_data, wbuf_q};
            word_d  = word_q + (ADDR_W+1)'(1);
            if (32'(word_q) + 32'd1 == 32'(len_q)) state_d = CHECK;
          end else begin
            wbuf_d[8*lane_q +: 8] = rx_data;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = RUN;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (boot_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Status outputs registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rx_ready_q  <= (state_d != RUN);
      cpu_reset_q <= (state_d != RUN);
      busy_q      <= (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == PAYLOAD) || (state_d == CHECK);
      done_q      <= (state_d == RUN);
    end
  end

  assign rx_ready   = rx_ready_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader with a 4-word memory (ADDR_W=2): a table of
// directed images, hand-written corner sequences, then random images checked
// against an image-level model (expected word list plus final status).
module tb_imem_boot_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          boot_req;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset, busy, done, err;

  imem_boot_loader #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .boot_req(boot_req), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit gaps   = 1'b0;
  bit prev_we = 1'b0;

  logic [AW-1:0] wr_a[$];
  logic [31:0]   wr_d[$];
  logic [7:0]    tx_q[$];
  logic [31:0]   exp_w[$];

  typedef struct {
    int                nb;
    logic [23:0][7:0]  b;    // b[nb-1] is the first byte sent
    int                nw;
    logic [3:0][31:0]  w;    // w[i] expected at address i
    bit                ed;
    bit                ee;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Capture every write strobe; two strobes in a row is itself an error.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_a.push_back(imem_addr);
      wr_d.push_back(imem_wdata);
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_back_to_back: got 1 want 0");
      end
    end
    prev_we <= imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    int tries;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tries = 0;
    while (!rx_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (!rx_ready) begin
      chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic go_idle();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    chk("boot_req cpu_reset", 32'(cpu_reset), 32'd1);
    chk("boot_req done", 32'(done), 32'd0);
  endtask

  // Send tx_q as one image, then compare status and captured writes to exp_w.
  task automatic run_img(input bit ed, input bit ee, input string tag);
    if (done) go_idle();
    wr_a.delete();
    wr_d.delete();
    foreach (tx_q[j]) begin
      if (j == tx_q.size() - 1) chk({tag, " cpu_reset_pre"}, 32'(cpu_reset), 32'd1);
      send_byte(tx_q[j]);
    end
    chk({tag, " done"},      32'(done),      32'(ed));
    chk({tag, " err"},       32'(err),       32'(ee));
    chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'(!ed));
    chk({tag, " rx_ready"},  32'(rx_ready),  32'(!ed));
    chk({tag, " busy"},      32'(busy),      32'd0);
    @(negedge clk); #1;
    chk({tag, " nwrites"}, 32'(wr_a.size()), 32'(exp_w.size()));
    foreach (exp_w[i]) begin
      if (i < wr_a.size()) begin
        chk({tag, " addr"}, 32'(wr_a[i]), 32'(i));
        chk({tag, " data"}, wr_d[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0;
    vt[0] = '{12, 192'({8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'hB3,8'h00,8'h00,8'h00,8'hA0}),
              2, 128'({32'h0,32'h0,32'h000000B3,32'h00000013}), 1'b1, 1'b0};
    vt[1] = '{12, 192'({8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'hB3,8'h00,8'h00,8'h00,8'h00}),
              2, 128'({32'h0,32'h0,32'h000000B3,32'h00000013}), 1'b0, 1'b1};
    vt[2] = vt[0];
    vt[3] = '{4, 192'({8'hA5,8'h00,8'h00,8'h00}), 0, '0, 1'b1, 1'b0};
    vt[4] = '{4, 192'({8'hA5,8'h00,8'h00,8'h01}), 0, '0, 1'b0, 1'b1};
    vt[5] = '{3, 192'({8'hA5,8'h05,8'h00}), 0, '0, 1'b0, 1'b1};
    vt[6] = '{20, 192'({8'hA5,8'h04,8'h00,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,
                        8'h08,8'h09,8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F,8'h00}),
              4, 128'({32'h0F0E0D0C,32'h0B0A0908,32'h07060504,32'h03020100}), 1'b1, 1'b0};
    vt[7] = '{10, 192'({8'h11,8'h22,8'hA5,8'h01,8'h00,8'hA5,8'hA5,8'hA5,8'hA5,8'h00}),
              1, 128'({32'h0,32'h0,32'h0,32'hA5A5A5A5}), 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst rx_ready",  32'(rx_ready),  32'd1);
    chk("rst we",        32'(imem_we),   32'd0);
    chk("rst busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst addr",      32'(imem_addr), 32'd0);
    chk("rst wdata",     imem_wdata,     32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed image table.
    for (int v = 0; v < 8; v++) begin
      tx_q.delete();
      exp_w.delete();
      for (int j = 0; j < vt[v].nb; j++) tx_q.push_back(vt[v].b[vt[v].nb-1-j]);
      for (int i = 0; i < vt[v].nw; i++) exp_w.push_back(vt[v].w[i]);
      run_img(vt[v].ed, vt[v].ee, $sformatf("vec%0d", v));
    end

    // Reset in the middle of a payload word: no write, outputs back to reset values.
    go_idle();
    wr_a.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid rx_ready",  32'(rx_ready),  32'd1);
    chk("mid busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("mid addr",  32'(imem_addr), 32'd0);
    chk("mid wdata", imem_wdata,     32'd0);
    repeat (2) @(negedge clk);
    chk("mid nwrites", 32'(wr_a.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    tx_q.delete(); exp_w.delete();
    for (int j = 0; j < vt[0].nb; j++) tx_q.push_back(vt[0].b[vt[0].nb-1-j]);
    for (int i = 0; i < vt[0].nw; i++) exp_w.push_back(vt[0].w[i]);
    run_img(1'b1, 1'b0, "reload");

    // boot_req in RUN while a byte is offered: byte refused, back to IDLE.
    rx_valid = 1'b1; rx_data = 8'hA5; boot_req = 1'b1;
    chk("run rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    boot_req = 1'b0; rx_valid = 1'b0;
    chk("breq cpu_reset", 32'(cpu_reset), 32'd1);
    chk("breq done",      32'(done),      32'd0);
    chk("breq busy",      32'(busy),      32'd0);
    send_byte(8'h33);
    chk("junk busy", 32'(busy), 32'd0);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    chk("idle breq ignored", 32'(cpu_reset), 32'd1);
    send_byte(8'hA5);
    chk("sync busy", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("empty done", 32'(done), 32'd1);

    // Random images against the image-level model.
    gaps = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int unsigned n;
      logic [7:0] cs, b;
      bit good;
      tx_q.delete();
      exp_w.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        tx_q.push_back(b == 8'hA5 ? 8'h5A : b);
      end
      n = $urandom_range(0, 5);
      if (n == 5) n = $urandom_range(5, 65535);
      tx_q.push_back(8'hA5);
      tx_q.push_back(n[7:0]);
      tx_q.push_back(n[15:8]);
      if (n > (1 << AW)) begin
        run_img(1'b0, 1'b1, $sformatf("rnd%0d", t));
      end else begin
        cs = 8'h00;
        for (int unsigned i = 0; i < n; i++) begin
          logic [31:0] w;
          for (int k = 0; k < 4; k++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            w[8*k +: 8] = b;
            cs ^= b;
            tx_q.push_back(b);
          end
          exp_w.push_back(w);
        end
        good = ($urandom_range(0, 4) != 0);
        tx_q.push_back(good ? cs : cs ^ 8'($urandom_range(1, 255)));
        run_img(good, !good, $sformatf("rnd%0d", t));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences CPU bring-up. Holds the pipelined core in reset while it receives a program image as a byte stream (UART receiver or debug link).
- Assembles the bytes into 32-bit little-endian words and writes them to the synchronous instruction memory starting at word 0.
- Verifies an XOR checksum, then releases the core's reset.
- Sits between the byte source, the instruction memory write port and the core's reset input.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity 2**ADDR_W words
SYNC, 8'hA5, start-of-image sync byte

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
rx_valid  in  1  byte available on rx_data
rx_data  in  8  stream byte
rx_ready  out  1  byte accepted when rx_valid & rx_ready at posedge clk
boot_req  in  1  single-cycle request to reload; honoured only in RUN
imem_we  out  1  instruction memory write strobe, one-cycle pulse
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  word to write
cpu_reset  out  1  reset to core, active-high
busy  out  1  high in LEN_LO, LEN_HI, PAYLOAD, CHECK
done  out  1  high in RUN
err  out  1  sticky error flag

Behaviour:
- Reset is asynchronous, active-high, clock is clk.
- Reset values:
  - state=IDLE
  - cpu_reset=1, rx_ready=1
  - imem_we=0, imem_addr=0, imem_wdata=0
  - busy=0, done=0, err=0
  - internal byte lane, word counter, length and checksum all 0
- Reset mid-image aborts the load; the partial word is discarded and nothing is written.
- All outputs are registered. cpu_reset=1 in every state except RUN.
- rx_ready=1 in all states except RUN, where it is 0. The loader never back-pressures during load.
- Image format:
  - SYNC
  - LEN_LO, LEN_HI (16-bit word count N, little-endian)
  - 4*N payload bytes, little-endian per word
  - one checksum byte = XOR of all payload bytes (0x00 when N=0)
- FSM (all transitions on an accepted byte unless noted):
  - IDLE: byte==SYNC -> LEN_LO and clear err, word counter, checksum. Other bytes are consumed and discarded.
  - LEN_LO: store N[7:0] -> LEN_HI.
  - LEN_HI: store N[15:8], then:
    - N > 2**ADDR_W -> ERROR
    - N==0 -> CHECK
    - otherwise -> PAYLOAD
  - PAYLOAD: byte k (k = lane 0..3) goes into imem_wdata[8k+7:8k]; checksum ^= byte. On lane 3:
    - imem_we pulses the following cycle, with imem_addr = word index and the full word on imem_wdata.
    - Word index increments after the write.
    - After word N-1 -> CHECK.
  - CHECK: byte==checksum -> RUN, else -> ERROR.
  - RUN: done=1, cpu_reset=0. The first deassertion happens the cycle after the checksum byte is accepted. boot_req=1 -> IDLE, with cpu_reset reasserted the next cycle.
  - ERROR: err=1, cpu_reset=1. Same byte handling as IDLE; a SYNC byte clears err and -> LEN_LO.
- imem_addr and imem_wdata hold their values between writes. imem_we is never high for two consecutive cycles.
- Maximum image (N=2**ADDR_W) writes addresses 0..2**ADDR_W-1; the word index never wraps.
- boot_req outside RUN is ignored.
- rx_valid during RUN is not accepted (rx_ready=0), regardless of boot_req.
- A SYNC byte value appearing inside length, payload or checksum is data, not a restart.

Test Plan:
1. Stream A5 02 00 13 00 00 00 B3 00 00 00, checksum A0 -> imem writes (addr0, 0x00000013), (addr1, 0x000000B3). cpu_reset falls one cycle after A0 is accepted; done=1, err=0.
2. Same image with checksum 00 -> ERROR: err=1, cpu_reset stays 1, done=0. Then send a valid image -> err clears on A5 and the load completes.
3. Stream A5 00 00 00 -> no imem_we; RUN with cpu_reset=0. Then A5 00 00 01 -> ERROR.
4. With ADDR_W=2, stream A5 05 00 -> ERROR immediately after the LEN_HI byte, with zero writes. With N=4, the writes use addresses 0..3 and no wrap.
5. Assert reset after 2 payload bytes -> all outputs return to reset values with no imem_we. Re-sending the full image loads correctly.
6. In RUN, pulse boot_req while rx_valid=1 -> rx_ready stays 0 that cycle, cpu_reset=1 the next cycle, state=IDLE. Bytes other than A5 are then discarded.
